mod_503_serial_reducer: RTL and testbench
=========================================

# mod_503_serial_reducer

Bit-serial Horner reducer that consumes a wide unsigned operand as a stream of 6-bit chunks, most significant chunk first, and returns its residue mod 503 as a 9-bit value. It receives operands of the same width and chunking that the mod-503 x_500 LUT network converts combinationally. It serves as a low-area alternative to that network and as a sequential cross-check against it. Ready/valid handshakes are used on both sides.

## Interface
Parameters:
- MOD, 503, modulus; fixed at 503, and any other value is unsupported.
- W, 9, residue width, equal to ceil(log2(MOD)).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  chunk offered.
- in_ready  out  1  block can accept a chunk this cycle.
- in_data  in  6  chunk value 0..63.
- in_last  in  1  offered chunk is the final (least significant) chunk of the operand.
- out_valid  out  1  residue available.
- out_ready  in  1  sink accepts the residue.
- out_res  out  9  residue 0..502.
- out_chunks  out  8  number of chunks in the operand (present only with MOD503_CNT_EN).

## Operation
- State machine states: IDLE, SHIFT, OUT.
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready, latch in_data into sh[5:0] and in_last into last_q, clear bit counter bc to 0, and go to SHIFT.
- SHIFT
  - in_ready=0, out_valid=0.
  - Each cycle: t = 2*acc + sh[5] (10-bit); acc ← (t ≥ 503) ? t−503 : t; sh ← sh<<1; bc ← bc+1.
  - One conditional subtraction suffices because acc ≤ 502 implies t ≤ 1005.
  - After the step with bc==5: go to OUT if last_q, else to IDLE.
- OUT
  - out_valid=1, out_res=acc, in_ready=0.
  - On out_ready: clear acc to 0 (and the chunk count) and go to IDLE.
- Invariant: acc ∈ [0,502] at all times. The result equals the operand value mod 503 for any number of chunks.
- The accumulator starts each operand at 0. A residue is only presented after a chunk with in_last=1.
- A single-chunk operand with in_last=1 is legal and yields in_data mod 503, which equals in_data.
- in_data and in_last are ignored whenever in_ready=0.
- out_res is stable and equals acc while out_valid=1. It is don't-care (it shows acc) otherwise.

## Timing
- Reset values: state=IDLE, acc=0, sh=0, bc=0, last_q=0, in_ready=1, out_valid=0, out_res=0, out_chunks=0.
- in_ready and out_valid are decoded directly from state registers, with no combinational path from inputs.
- Accept at rising edge T; SHIFT occupies edges T+1..T+6.
- For a non-last chunk, in_ready returns high after edge T+6, so peak throughput is one chunk per 7 cycles.
- For a last chunk, out_valid rises after edge T+6. Residue latency is 6 cycles from the accept edge of the final chunk.
- If out_ready is already high while out_valid=1, the transfer completes on the next edge. in_ready=1 follows the cycle after.
- Backpressure: out_valid and out_res are held indefinitely while out_ready=0, and no chunk is accepted in OUT.
- Asynchronous reset in any state, including mid-SHIFT or with out_valid=1, immediately forces the reset values. The partial operand is discarded with no residue produced.

## Configuration
- MOD503_CNT_EN defined:
  - Adds the out_chunks port and an 8-bit counter, incremented on each accepted chunk and saturating at 255.
  - The counter is valid with out_valid and cleared on the output handshake and by reset.
- MOD503_CNT_EN undefined: the port and counter are absent. All other behaviour and timing are identical.

## Test plan
- Single chunk in_data=63, in_last=1 → out_res=63; out_valid rises 6 cycles after accept.
- Chunks [7,55]: 7·64+55=503 → out_res=0. With MOD503_CNT_EN, out_chunks=2.
- Chunks [63,63]: 4095 → out_res=71. Chunks [1,0,0]: 4096 → out_res=72.
- Random 1–40 chunk operands against a reference model of value mod 503. Back-to-back in_valid=1 shows in_ready low for exactly 6 cycles after each accept.
- out_ready held low 5 cycles after out_valid: out_res stays constant and in_ready stays 0. Then out_ready=1 → out_valid=0 and in_ready=1 on the next cycle.
- Assert rst_n=0 at bc=3 of the second chunk of [7,55] → all outputs at reset values immediately. A following chunk [10] with in_last=1 → out_res=10 (no residual accumulator state).

Source files
------------

// File: rtl/mod_503_serial_reducer.sv
// Bit-serial Horner reducer: folds 6-bit chunks (MS chunk first) into a residue mod 503.
// Optional chunk counter on out_chunks_o when MOD503_CNT_EN is defined.
module mod_503_serial_reducer #(
    parameter int unsigned MOD = 503,
    parameter int unsigned W   = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [5:0]   in_data_i,
    input  logic         in_last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_res_o
`ifdef MOD503_CNT_EN
    , output logic [7:0] out_chunks_o
`endif
);

    typedef enum logic [1:0] {StIdle, StShift, StOut} state_e;

    state_e         state_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   acc_d;
    logic [5:0]     sh_q;
    logic [2:0]     bc_q;
    logic           last_q;
    logic [W:0]     t;

    // acc <= 502 keeps t <= 1005, so a single conditional subtract is enough.
    always_comb begin
        t     = {acc_q, 1'b0} + {{W{1'b0}}, sh_q[5]};
        acc_d = (t >= (W+1)'(MOD)) ? W'(t - (W+1)'(MOD)) : t[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            sh_q    <= '0;
            bc_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        sh_q    <= in_data_i;
                        last_q  <= in_last_i;
                        bc_q    <= '0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    acc_q <= acc_d;
                    sh_q  <= {sh_q[4:0], 1'b0};
                    bc_q  <= bc_q + 3'd1;
                    if (bc_q == 3'd5) begin
                        state_q <= last_q ? StOut : StIdle;
                    end
                end
                StOut: begin
                    if (out_ready_i) begin
                        acc_q   <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StOut);
    assign out_res_o   = acc_q;

`ifdef MOD503_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == StIdle && in_valid_i) begin
            if (cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end else if (state_q == StOut && out_ready_i) begin
            cnt_q <= '0;
        end
    end

    assign out_chunks_o = cnt_q;
`endif

endmodule

// File: tb/tb_mod_503_serial_reducer.sv
// Self-checking bench for mod_503_serial_reducer: directed vectors plus random operands
// against a chunk-level value-mod-503 reference model.
module tb_mod_503_serial_reducer;

    logic       clk;
    logic       rst_n;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [5:0] in_data_i;
    logic       in_last_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [8:0] out_res_o;
`ifdef MOD503_CNT_EN
    logic [7:0] out_chunks_o;
`endif

    int n_total = 0;
    int n_bad   = 0;

    mod_503_serial_reducer #(.MOD(503), .W(9)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_res_o   (out_res_o)
`ifdef MOD503_CNT_EN
        , .out_chunks_o(out_chunks_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: operand value mod 503, one chunk at a time.
    function automatic int ref_mod(input int chunks[$]);
        int r = 0;
        foreach (chunks[i]) r = (r * 64 + chunks[i]) % 503;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after SHIFT finishes.
    task automatic send_chunk(input logic [5:0] d, input bit last, input bit junk);
        int guard = 0;
        while (!in_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_eq("ready_timeout", 0, 1);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        @(posedge clk);
        #1;
        in_valid_i = junk;
        in_data_i  = 6'($urandom);
        in_last_i  = 1'($urandom);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("busy_in_ready", 32'(in_ready_o), 0);
            check_eq("busy_out_valid", 32'(out_valid_o), 0);
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        check_eq("done_in_ready", 32'(in_ready_o), 32'(!last));
        check_eq("done_out_valid", 32'(out_valid_o), 32'(last));
    endtask

    // Called at the negedge where out_valid is first expected high.
    task automatic take_result(input int exp_res, input int exp_cnt, input int hold);
        check_eq("out_valid", 32'(out_valid_o), 1);
        check_eq("out_res", 32'(out_res_o), 32'(exp_res));
`ifdef MOD503_CNT_EN
        check_eq("out_chunks", 32'(out_chunks_o), 32'(exp_cnt > 255 ? 255 : exp_cnt));
`endif
        out_ready_i = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid_o), 1);
            check_eq("hold_res", 32'(out_res_o), 32'(exp_res));
            check_eq("hold_in_ready", 32'(in_ready_o), 0);
        end
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        @(negedge clk);
        check_eq("post_valid", 32'(out_valid_o), 0);
        check_eq("post_in_ready", 32'(in_ready_o), 1);
    endtask

    task automatic run_operand(input int chunks[$], input bit junk, input int hold);
        for (int i = 0; i < chunks.size(); i++) begin
            send_chunk(6'(chunks[i]), i == chunks.size() - 1, junk);
        end
        take_result(ref_mod(chunks), chunks.size(), hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready_o), 1);
        check_eq({tag, "_out_valid"}, 32'(out_valid_o), 0);
        check_eq({tag, "_out_res"}, 32'(out_res_o), 0);
`ifdef MOD503_CNT_EN
        check_eq({tag, "_out_chunks"}, 32'(out_chunks_o), 0);
`endif
    endtask

    initial begin
        int ops[$];
        int n;

        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with known residues.
        ops = '{63};
        run_operand(ops, 1'b0, 0);
        check_eq("ref_63", 32'(ref_mod(ops)), 63);
        ops = '{7, 55};
        run_operand(ops, 1'b1, 0);
        ops = '{63, 63};
        run_operand(ops, 1'b0, 0);
        ops = '{1, 0, 0};
        run_operand(ops, 1'b1, 0);

        // Backpressure: out_ready low for 5 cycles.
        ops = '{12, 34, 56};
        run_operand(ops, 1'b1, 5);

        // Asynchronous reset at bc==3 of the second chunk of [7,55].
        send_chunk(6'd7, 1'b0, 1'b0);
        in_valid_i = 1'b1;
        in_data_i  = 6'd55;
        in_last_i  = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ops = '{10};
        run_operand(ops, 1'b0, 0);

        // Random operands of 1..40 chunks.
        for (int op = 0; op < 20; op++) begin
            ops.delete();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) ops.push_back($urandom_range(0, 63));
            run_operand(ops, 1'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
